// File: rtl/d_victim_cache_array_if.sv
`default_nettype none
// ============================================================================
// Module   : d_victim_cache_array_if
// Brief    : Request/response/writeback bundle for the D-cache victim cache.
//            Optional stat_* signals exist only when D_VC_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
interface d_victim_cache_array_if #(
  parameter int TAG_W  = 26,
  parameter int LINE_W = 128
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_op_i;
  logic [TAG_W-1:0]  req_tag_i;
  logic [LINE_W-1:0] req_data_i;
  logic              req_dirty_i;
  logic              rsp_valid_o;
  logic              rsp_hit_o;
  logic [LINE_W-1:0] rsp_data_o;
  logic              rsp_dirty_o;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [TAG_W-1:0]  wb_tag_o;
  logic [LINE_W-1:0] wb_data_o;
  logic              busy_o;
`ifdef D_VC_STATS_EN
  logic [31:0]       stat_hit_o;
  logic [31:0]       stat_miss_o;
  logic [31:0]       stat_wb_o;
`endif

  modport slave (
    input  req_valid_i, req_op_i, req_tag_i, req_data_i, req_dirty_i, wb_ready_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_data_o, rsp_dirty_o,
    output wb_valid_o, wb_tag_o, wb_data_o, busy_o
`ifdef D_VC_STATS_EN
    , output stat_hit_o, stat_miss_o, stat_wb_o
`endif
  );

  modport master (
    output req_valid_i, req_op_i, req_tag_i, req_data_i, req_dirty_i, wb_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_data_o, rsp_dirty_o,
    input  wb_valid_o, wb_tag_o, wb_data_o, busy_o
`ifdef D_VC_STATS_EN
    , input stat_hit_o, stat_miss_o, stat_wb_o
`endif
  );
endinterface
`default_nettype wire

// File: rtl/d_victim_cache_array.sv
`default_nettype none
// ============================================================================
// Module   : d_victim_cache_array
// Brief    : Fully associative victim cache (tag/valid/dirty/data, round-robin
//            replacement, dirty writeback, flush). Optional hit/miss/writeback
//            counters when D_VC_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
module d_victim_cache_array #(
  parameter int WAYS   = 4,
  parameter int TAG_W  = 26,
  parameter int LINE_W = 128
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  d_victim_cache_array_if.slave  bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam logic [WAY_W-1:0] c_LAST_WAY  = WAY_W'(WAYS - 1);
  localparam logic [1:0]       c_OP_LOOKUP = 2'b00;
  localparam logic [1:0]       c_OP_INSERT = 2'b01;
  localparam logic [1:0]       c_OP_FLUSH  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WB_WAIT    = 2'd1,
    S_FLUSH_SCAN = 2'd2,
    S_FLUSH_WB   = 2'd3
  } state_t;

  state_t            r_state;
  logic [WAYS-1:0]   r_valid;
  logic [WAYS-1:0]   r_dirty;
  logic [TAG_W-1:0]  r_tag  [WAYS];
  logic [LINE_W-1:0] r_data [WAYS];
  logic [WAY_W-1:0]  r_ptr;
  logic [WAY_W-1:0]  r_scan;
  logic              r_rsp_valid;
  logic              r_rsp_hit;
  logic [LINE_W-1:0] r_rsp_data;
  logic              r_rsp_dirty;
  logic              r_wb_valid;
  logic [TAG_W-1:0]  r_wb_tag;
  logic [LINE_W-1:0] r_wb_data;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_lookup;
  logic              w_insert;
  logic              w_flush;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_idx;
  logic              w_free;
  logic [WAY_W-1:0]  w_free_idx;
  logic [WAY_W-1:0]  w_ins_way;
  logic              w_evict_dirty;
  logic              w_wb_done;

  assign w_req_ready = (r_state == S_IDLE) && !r_wb_valid;
  assign w_accept    = bus.req_valid_i && w_req_ready;
  assign w_lookup    = w_accept && (bus.req_op_i == c_OP_LOOKUP);
  assign w_insert    = w_accept && (bus.req_op_i == c_OP_INSERT);
  assign w_flush     = w_accept && (bus.req_op_i == c_OP_FLUSH);
  assign w_wb_done   = r_wb_valid && bus.wb_ready_i;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == bus.req_tag_i)) begin
        w_hit     = 1'b1;
        w_hit_idx = WAY_W'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = WAY_W'(i);
      end
    end
  end

  assign w_ins_way     = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_ptr);
  assign w_evict_dirty = w_insert && !w_hit && !w_free && r_dirty[r_ptr];

  // Line storage is intentionally not reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (w_insert) begin
      r_tag[w_ins_way]  <= bus.req_tag_i;
      r_data[w_ins_way] <= bus.req_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_ptr       <= '0;
      r_scan      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_dirty <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_tag    <= '0;
      r_wb_data   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_dirty <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_lookup) begin
            r_rsp_valid <= 1'b1;
            if (w_hit) begin
              r_rsp_hit          <= 1'b1;
              r_rsp_data         <= r_data[w_hit_idx];
              r_rsp_dirty        <= r_dirty[w_hit_idx];
              r_valid[w_hit_idx] <= 1'b0;
            end
          end else if (w_insert) begin
            r_valid[w_ins_way] <= 1'b1;
            if (w_hit) begin
              r_dirty[w_ins_way] <= r_dirty[w_ins_way] | bus.req_dirty_i;
            end else begin
              r_dirty[w_ins_way] <= bus.req_dirty_i;
            end
            if (!w_hit && !w_free) begin
              r_ptr <= r_ptr + WAY_W'(1);
            end
            if (w_evict_dirty) begin
              r_wb_valid <= 1'b1;
              r_wb_tag   <= r_tag[r_ptr];
              r_wb_data  <= r_data[r_ptr];
              r_state    <= S_WB_WAIT;
            end
          end else if (w_flush) begin
            r_scan  <= '0;
            r_state <= S_FLUSH_SCAN;
          end
        end
        S_WB_WAIT: begin
          if (bus.wb_ready_i) begin
            r_wb_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_FLUSH_SCAN: begin
          if (r_valid[r_scan] && r_dirty[r_scan]) begin
            r_wb_valid <= 1'b1;
            r_wb_tag   <= r_tag[r_scan];
            r_wb_data  <= r_data[r_scan];
            r_state    <= S_FLUSH_WB;
          end else begin
            r_valid[r_scan] <= 1'b0;
            r_dirty[r_scan] <= 1'b0;
            if (r_scan == c_LAST_WAY) begin
              r_ptr   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_scan <= r_scan + WAY_W'(1);
            end
          end
        end
        S_FLUSH_WB: begin
          if (bus.wb_ready_i) begin
            r_wb_valid      <= 1'b0;
            r_valid[r_scan] <= 1'b0;
            r_dirty[r_scan] <= 1'b0;
            if (r_scan == c_LAST_WAY) begin
              r_ptr   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_scan  <= r_scan + WAY_W'(1);
              r_state <= S_FLUSH_SCAN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef D_VC_STATS_EN
  logic [31:0] r_stat_hit;
  logic [31:0] r_stat_miss;
  logic [31:0] r_stat_wb;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_hit  <= '0;
      r_stat_miss <= '0;
      r_stat_wb   <= '0;
    end else begin
      if (w_lookup && w_hit && (r_stat_hit != 32'hFFFF_FFFF)) begin
        r_stat_hit <= r_stat_hit + 32'd1;
      end
      if (w_lookup && !w_hit && (r_stat_miss != 32'hFFFF_FFFF)) begin
        r_stat_miss <= r_stat_miss + 32'd1;
      end
      if (w_wb_done && (r_stat_wb != 32'hFFFF_FFFF)) begin
        r_stat_wb <= r_stat_wb + 32'd1;
      end
    end
  end

  assign bus.stat_hit_o  = r_stat_hit;
  assign bus.stat_miss_o = r_stat_miss;
  assign bus.stat_wb_o   = r_stat_wb;
`else
  logic w_unused_wb_done;
  assign w_unused_wb_done = w_wb_done;
`endif

  assign bus.req_ready_o = w_req_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_hit_o   = r_rsp_hit;
  assign bus.rsp_data_o  = r_rsp_data;
  assign bus.rsp_dirty_o = r_rsp_dirty;
  assign bus.wb_valid_o  = r_wb_valid;
  assign bus.wb_tag_o    = r_wb_tag;
  assign bus.wb_data_o   = r_wb_data;
  assign bus.busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/d_victim_cache_array.md
Name: d_victim_cache_array

Overview:
- Parametrised, fully associative victim cache storage for the D-cache: tag, valid and dirty bits, line data, and round-robin replacement in one block.
- Sits between the L1 D-cache controller and the memory writeback path.
- Accepts lookup (swap-out), insert (L1 eviction) and flush requests over a valid/ready handshake.
- Emits dirty victims on a separate writeback valid/ready channel.

Parameters:
WAYS, 4, number of fully associative entries; power of two, 2..16
TAG_W, 26, tag width (line address bits above the offset)
LINE_W, 128, line data width in bits
WAY_W, $clog2(WAYS), way index width (derived, not overridable)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  block can accept a request this cycle
req_op_i  in  2  00 LOOKUP, 01 INSERT, 10 FLUSH, 11 reserved (no-op, still handshaken)
req_tag_i  in  TAG_W  tag for LOOKUP/INSERT
req_data_i  in  LINE_W  line for INSERT
req_dirty_i  in  1  dirty flag for INSERT
rsp_valid_o  out  1  LOOKUP response valid, one-cycle pulse
rsp_hit_o  out  1  LOOKUP hit
rsp_data_o  out  LINE_W  hit line (0 on miss)
rsp_dirty_o  out  1  hit line dirty flag
wb_valid_o  out  1  writeback line valid
wb_ready_i  in  1  writeback sink accepts
wb_tag_o  out  TAG_W  writeback tag
wb_data_o  out  LINE_W  writeback line
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (async, active-high):
  - All valid and dirty bits cleared; replacement pointer = 0; FSM in IDLE.
  - Outputs: rsp_*=0, wb_*=0, busy_o=0, req_ready_o=1 once reset is released.
  - Data and tag arrays are not reset.
- Handshake: a request is accepted when req_valid_i && req_ready_o at a rising edge. req_ready_o = (state==IDLE) && !wb_valid_o.
- FSM states: IDLE, WB_WAIT, FLUSH_SCAN, FLUSH_WB.
- LOOKUP, accepted in IDLE:
  - Parallel compare of req_tag_i against all valid entries.
  - Response on the next cycle: rsp_valid_o=1 for one cycle, with rsp_hit_o, rsp_data_o and rsp_dirty_o.
  - On hit, the entry's valid bit is cleared on that same accepting edge (the line swaps into L1).
  - Miss: rsp_hit_o=0, rsp_data_o=0, rsp_dirty_o=0, no state change. Stays in IDLE.
- INSERT, accepted in IDLE. Way selection priority:
  1. A valid entry whose tag matches: overwrite its data; dirty |= req_dirty_i; no writeback.
  2. Lowest-index invalid way.
  3. Way at the replacement pointer, then pointer increments modulo WAYS.
  - Pointer advances only in case 3.
  - If the way chosen in case 3 is valid and dirty:
    - Its old tag and data are registered onto the wb_* outputs; wb_valid_o=1 from the next cycle.
    - The new line is written on the same edge; FSM -> WB_WAIT.
  - Any other insert completes in one cycle; FSM stays in IDLE.
- WB_WAIT:
  - wb_valid_o and the wb_* payload are held stable until wb_ready_i=1 at an edge.
  - wb_valid_o drops on the cycle after that edge; FSM -> IDLE.
- FLUSH, accepted in IDLE: FSM -> FLUSH_SCAN with scan index 0.
  - FLUSH_SCAN, each cycle, for entry[scan index]:
    - Valid and dirty: load wb_* and go to FLUSH_WB.
    - Otherwise: clear valid and increment the scan index.
  - FLUSH_WB: hold until wb_ready_i; then clear the entry's valid and dirty bits, increment the scan index, return to FLUSH_SCAN.
  - After entry WAYS-1 is processed, FSM -> IDLE and the pointer resets to 0.
  - Latency: WAYS cycles plus one handshake per dirty line.
- wb_ready_i held high: writeback completes in one cycle (wb_valid_o high for exactly one cycle).
- Hazards: only one request is in flight at a time, so there are no simultaneous-access hazards. Reserved op: accepted, no effect, no response.
- Reset mid-operation: FSM is forced to IDLE, a pending writeback is dropped (wb_valid_o=0), and all entries are invalidated.

Optional Feature:
- Macro: D_VC_STATS_EN.
- When defined, adds outputs:
  - stat_hit_o [31:0]: LOOKUP hits.
  - stat_miss_o [31:0]: LOOKUP misses.
  - stat_wb_o [31:0]: completed writebacks.
  - All three reset to 0, saturate at 32'hFFFF_FFFF, and update on the edge where the event is recorded.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then LOOKUP tag 0x123 -> next cycle rsp_valid_o=1, rsp_hit_o=0, rsp_data_o=0; busy_o=0 throughout.
- INSERT tag 0x10 with data 0xA5..A5, dirty=0; then LOOKUP 0x10 -> hit, data 0xA5..A5, dirty=0; a second LOOKUP 0x10 -> miss (the entry was swapped out).
- WAYS=4: INSERT tags 1..4, all dirty, then INSERT tag 5 -> way 0 replaced; wb_valid_o=1 with wb_tag_o=1; with wb_ready_i low for 3 cycles the payload is stable and req_ready_o=0; after ready, pointer=1.
- INSERT tag 7 dirty=0, then INSERT tag 7 dirty=1 with new data -> single entry, no writeback, later LOOKUP returns the new data with dirty=1.
- Fill 4 ways with ways 1 and 3 dirty, then FLUSH with wb_ready_i=1 -> exactly two writebacks, in way order (1 then 3); afterwards every LOOKUP misses and busy_o falls after 4 scan cycles plus the writebacks.
- Assert rst_i while in WB_WAIT -> wb_valid_o=0 immediately; after release, LOOKUP of a previously inserted tag misses; with D_VC_STATS_EN, the counters read 0.
